// File: rtl/cam_vga_linebuf_pkg.sv
// cam_vga_pkg: shared types, 640x480@60 defaults and helpers for the camera-to-VGA bridge
package cam_vga_pkg;
  typedef enum logic [1:0] {
    FMT_RGB565 = 2'd0,
    FMT_RGB555 = 2'd1,
    FMT_YUV422 = 2'd2
  } pix_fmt_e;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic rgb888_t to_rgb888(pix_fmt_e fmt, logic [15:0] w);
    rgb888_t p;
    p.r = fmt == FMT_YUV422 ? w[15:8] : fmt == FMT_RGB555 ? {w[14:10], w[14:12]} : {w[15:11], w[15:13]};
    p.g = fmt == FMT_YUV422 ? w[15:8] : fmt == FMT_RGB555 ? {w[9:5], w[9:7]} : {w[10:5], w[10:9]};
    p.b = fmt == FMT_YUV422 ? w[15:8] : {w[4:0], w[4:2]};
    return p;
  endfunction
endpackage

// File: rtl/cam_vga_linebuf_pixel_fifo.sv
// pixel_fifo: single-clock FIFO with exact level, flush, and push accepted on full when a pop frees a slot
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  // Accept/advance logic; a pop on empty never bypasses a same-cycle push
  always_comb begin
    empty   = level_q == '0;
    full    = level_q[AW];
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = flush ? '0 : wr_q + AW'(do_push);
    rd_d    = flush ? '0 : rd_q + AW'(do_pop);
    level_d = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
  end
  // Pointer and level registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  // Storage array, no reset needed since level gates every read
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign level = level_q;
endmodule

// File: rtl/cam_vga_linebuf.sv
// cam_vga_linebuf: byte-serial camera capture into a pixel FIFO, replayed through a genlocked VGA timing generator
module cam_vga_linebuf import cam_vga_pkg::*; #(
  parameter int          H_ACTIVE      = DEF_H_ACTIVE,
  parameter int          H_FP          = DEF_H_FP,
  parameter int          H_SYNC        = DEF_H_SYNC,
  parameter int          H_BP          = DEF_H_BP,
  parameter int          V_ACTIVE      = DEF_V_ACTIVE,
  parameter int          V_FP          = DEF_V_FP,
  parameter int          V_SYNC        = DEF_V_SYNC,
  parameter int          V_BP          = DEF_V_BP,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int          FIFO_DEPTH    = 1024,
  parameter int          PIX_FMT       = 0,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        xclk,
  input  logic                        cam_href,
  input  logic                        cam_vsync,
  input  logic [7:0]                  cam_data,
  input  logic                        clear_status,
  output logic                        VGA_CLK,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic                        VGA_BLANK_n,
  output logic                        VGA_SYNC_n,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam pix_fmt_e FMT = pix_fmt_e'(PIX_FMT[1:0]);
  logic href_q, href_d, vsync_q, vsync_d, vsync2_q, vsync2_d, phase_q, phase_d;
  logic [7:0] data_q, data_d, hi_q, hi_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d;
  logic hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d;
  rgb888_t rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic genlock, push, pop, active, h_wrap, fifo_full, fifo_empty;
  rgb888_t push_rgb, fifo_rgb;
  pixel_fifo #(.WIDTH(24), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .flush(genlock),
    .push (push),
    .pop  (pop),
    .wdata(push_rgb),
    .rdata(fifo_rgb),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );
  // Capture: register camera pins, pair bytes into pixels, detect the vsync rising edge
  always_comb begin
    href_d   = cam_href;
    vsync_d  = cam_vsync;
    vsync2_d = vsync_q;
    data_d   = cam_data;
    genlock  = vsync_q & ~vsync2_q;
    phase_d  = href_q & ~phase_q & ~genlock;
    hi_d     = (href_q & ~phase_q) ? data_q : hi_q;
    push     = href_q & phase_q & ~genlock;
    push_rgb = to_rgb888(FMT, {hi_q, data_q});
  end
  // Timing counters, two-stage output pipeline and sticky status
  always_comb begin
    h_wrap      = h_cnt_q == HW'(H_TOTAL - 1);
    h_cnt_d     = (genlock || h_wrap) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d     = genlock ? VW'(V_ACTIVE) : !h_wrap ? v_cnt_q : v_cnt_q == VW'(V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
    active      = h_cnt_q < HW'(H_ACTIVE) && v_cnt_q < VW'(V_ACTIVE);
    pop         = active & ~fifo_empty;
    hs1_d       = (h_cnt_q >= HW'(H_ACTIVE + H_FP) && h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    vs1_d       = (v_cnt_q >= VW'(V_ACTIVE + V_FP) && v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    blank1_d    = active;
    rgb1_d      = !active ? '0 : fifo_empty ? rgb888_t'(UNDERFLOW_RGB) : fifo_rgb;
    hs2_d       = hs1_q;
    vs2_d       = vs1_q;
    blank2_d    = blank1_q;
    rgb2_d      = rgb1_q;
    overflow_d  = !genlock && ((push & fifo_full & ~pop) || (overflow_q & ~clear_status));
    underflow_d = !genlock && ((active & fifo_empty) || (underflow_q & ~clear_status));
  end
  // State registers; reset leaves syncs inactive and the picture black
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      vsync2_q    <= 1'b0;
      data_q      <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hs1_q       <= ~HS_POL;
      vs1_q       <= ~VS_POL;
      blank1_q    <= 1'b0;
      rgb1_q      <= '0;
      hs2_q       <= ~HS_POL;
      vs2_q       <= ~VS_POL;
      blank2_q    <= 1'b0;
      rgb2_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      href_q      <= href_d;
      vsync_q     <= vsync_d;
      vsync2_q    <= vsync2_d;
      data_q      <= data_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      blank1_q    <= blank1_d;
      rgb1_q      <= rgb1_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      blank2_q    <= blank2_d;
      rgb2_q      <= rgb2_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  assign xclk        = clk;
  assign VGA_CLK     = clk;
  assign VGA_SYNC_n  = 1'b1;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_n = blank2_q;
  assign VGA_R       = rgb2_q.r;
  assign VGA_G       = rgb2_q.g;
  assign VGA_B       = rgb2_q.b;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
endmodule

// File: tb/tb_cam_vga_linebuf.sv
// tb_cam_vga_linebuf: directed checks of timing, capture, format conversion, FIFO status and genlock
module tb_cam_vga_linebuf;
  logic clk = 1'b0, reset = 1'b0, cam_href = 1'b0, cam_vsync = 1'b0, clear_status = 1'b0;
  logic [7:0] cam_data = 8'h00;
  int n_chk = 0, n_pass = 0;
  logic a_xclk, a_vclk, a_hs, a_vs, a_bl, a_sn, a_ovf, a_udf;
  logic b_xclk, b_vclk, b_hs, b_vs, b_bl, b_sn, b_ovf, b_udf;
  logic c_xclk, c_vclk, c_hs, c_vs, c_bl, c_sn, c_ovf, c_udf;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic [10:0] a_lvl;
  logic [6:0] b_lvl;
  logic [4:0] c_lvl;
  always #20 clk = ~clk;
  cam_vga_linebuf dut_a (
    .clk(clk), .reset(reset), .xclk(a_xclk), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .clear_status(clear_status), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_n(a_bl), .VGA_SYNC_n(a_sn), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .fifo_level(a_lvl), .overflow(a_ovf), .underflow(a_udf));
  cam_vga_linebuf #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
                    .V_BP(2), .FIFO_DEPTH(64)) dut_b (
    .clk(clk), .reset(reset), .xclk(b_xclk), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .clear_status(clear_status), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_n(b_bl), .VGA_SYNC_n(b_sn), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .fifo_level(b_lvl), .overflow(b_ovf), .underflow(b_udf));
  cam_vga_linebuf #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
                    .V_BP(2), .FIFO_DEPTH(16), .PIX_FMT(2)) dut_c (
    .clk(clk), .reset(reset), .xclk(c_xclk), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .clear_status(clear_status), .VGA_CLK(c_vclk), .VGA_HS(c_hs), .VGA_VS(c_vs),
    .VGA_BLANK_n(c_bl), .VGA_SYNC_n(c_sn), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b),
    .fifo_level(c_lvl), .overflow(c_ovf), .underflow(c_udf));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    tick(1);
    reset = 1'b1;
    cam_href = 1'b0;
    cam_vsync = 1'b0;
    cam_data = 8'h00;
    clear_status = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic genlock();
    tick(1);
    cam_vsync = 1'b1;
    tick(2);
    cam_vsync = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] d);
    tick(1);
    cam_href = 1'b1;
    cam_data = d;
  endtask
  task automatic end_row();
    tick(1);
    cam_href = 1'b0;
    tick(1);
  endtask
  task automatic send_pix(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
  endtask
  task automatic pulse_clear();
    tick(1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
  endtask
  task automatic hs_first(output int k);
    k = 0;
    for (int i = 1; i <= 700 && k == 0; i++) begin
      tick(1);
      if (!a_hs) k = i;
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int f1, f2, low, bl, bad, k;
    logic prev;
    #5 reset = 1'b1;
    #1;
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_blank", a_bl, 0);
    check("rst_rgb", {a_r, a_g, a_b}, 0);
    check("rst_lvl", a_lvl, 0);
    check("rst_flags", {a_ovf, a_udf}, 0);
    check("sync_n", a_sn, 1);
    tick(2);
    reset = 1'b0;
    f1 = 0; f2 = 0; low = 0; bl = 0; prev = a_hs;
    for (int i = 1; i <= 1600; i++) begin
      tick(1);
      if (prev && !a_hs) begin
        if (f1 == 0) f1 = i;
        else if (f2 == 0) f2 = i;
      end
      prev = a_hs;
      if (i <= 800 && !a_hs) low++;
      if (i <= 800 && a_bl) bl++;
      if (i == 2) check("a_udf_rgb", {a_r, a_g, a_b}, 24'hFF00FF);
      if (i == 3) check("a_udf_flag", a_udf, 1);
      if (i == 700) check("a_blank_rgb", {a_r, a_g, a_b}, 0);
    end
    check("a_hs_first", f1, 658);
    check("a_hs_period", f2 - f1, 800);
    check("a_hs_low", low, 96);
    check("a_blank_cnt", bl, 640);
    genlock();
    send_pix(16'hF800, 8);
    end_row();
    check("a_lvl8", a_lvl, 8);
    #3 reset = 1'b1;
    #1;
    check("amid_lvl", a_lvl, 0);
    check("amid_hs_vs", {a_hs, a_vs}, 2'b11);
    check("amid_blank", a_bl, 0);
    check("amid_rgb", {a_r, a_g, a_b}, 0);
    tick(1);
    reset = 1'b0;
    hs_first(k);
    check("a_hs_after_rst", k, 658);
    do_reset();
    f1 = 0; f2 = 0; low = 0; bl = 0; prev = b_vs;
    for (int i = 1; i <= 600; i++) begin
      tick(1);
      if (prev && !b_vs) begin
        if (f1 == 0) f1 = i;
        else if (f2 == 0) f2 = i;
      end
      prev = b_vs;
      if (i <= 275 && !b_vs) low++;
      if (i <= 275 && b_bl) bl++;
    end
    check("b_vs_first", f1, 177);
    check("b_vs_period", f2 - f1, 275);
    check("b_vs_low", low, 50);
    check("b_blank_cnt", bl, 96);
    check("b_udf_free", b_udf, 1);
    do_reset();
    genlock();
    send_pix(16'hF800, 16);
    end_row();
    send_byte(8'hF8);
    send_byte(8'h00);
    send_byte(8'hAA);
    end_row();
    send_pix(16'h07E0, 1);
    end_row();
    check("b_lvl18", b_lvl, 18);
    pulse_clear();
    check("b_udf_clr", b_udf, 0);
    for (int i = 0; i < 400 && !b_bl; i++) tick(1);
    check("b_wait_l0", b_bl, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if ({b_r, b_g, b_b} !== 24'hFF0000 || !b_bl) bad++;
      tick(1);
    end
    check("b_l0_red", bad, 0);
    check("b_l0_udf", b_udf, 0);
    check("b_l0_lvl", b_lvl, 2);
    for (int i = 0; i < 400 && !b_bl; i++) tick(1);
    check("b_wait_l1", b_bl, 1);
    check("b_odd_pix", {b_r, b_g, b_b}, 24'hFF0000);
    tick(1);
    check("b_next_row", {b_r, b_g, b_b}, 24'h00FF00);
    tick(1);
    check("b_empty_pix", {b_r, b_g, b_b}, 24'hFF00FF);
    check("b_l1_udf", b_udf, 1);
    check("b_lvl0", b_lvl, 0);
    do_reset();
    genlock();
    send_pix(16'h8010, 20);
    tick(1);
    cam_href = 1'b0;
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    check("c_lvl_full", c_lvl, 16);
    check("c_ovf_set_wins", c_ovf, 1);
    pulse_clear();
    check("c_ovf_clr", c_ovf, 0);
    for (int i = 0; i < 400 && !c_bl; i++) tick(1);
    check("c_wait_l0", c_bl, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if ({c_r, c_g, c_b} !== 24'h808080 || !c_bl) bad++;
      tick(1);
    end
    check("c_grey", bad, 0);
    check("c_udf", c_udf, 0);
    check("c_lvl0", c_lvl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
